// File: rtl/sprite_frame_animator.sv
// Sprite-ROM address generator with an idle/walk/jump animation FSM.
// Frame/mirror state advances only on frame_tick; the address path is one registered stage.
module sprite_frame_animator #(
    parameter int SPR_W       = 20,
    parameter int SPR_H       = 40,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8,
    parameter int COORD_W     = 10,
    parameter int ADDR_W      = 19,
    parameter int BASE_ADDR   = 0
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          frame_tick,
    input  logic                          walking,
    input  logic                          jumping,
    input  logic                          facing_left,
    input  logic [COORD_W-1:0]            drawxsig,
    input  logic [COORD_W-1:0]            drawysig,
    input  logic [COORD_W-1:0]            spritexsig,
    input  logic [COORD_W-1:0]            spriteysig,
    output logic [ADDR_W-1:0]             read_address_mario,
    output logic                          pixel_valid,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_number
);

    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int SW = COORD_W + 2;

    localparam logic [FW-1:0] FR_IDLE = '0;
    localparam logic [FW-1:0] FR_LO   = FW'(1);
    localparam logic [FW-1:0] FR_HI   = FW'(NUM_FRAMES - 2);
    localparam logic [FW-1:0] FR_JUMP = FW'(NUM_FRAMES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_TICKS - 1);

    localparam logic signed [SW-1:0] HALF_W = SW'(SPR_W / 2);
    localparam logic signed [SW-1:0] HALF_H = SW'(SPR_H / 2);
    localparam logic signed [SW-1:0] LIM_W  = SW'(SPR_W);
    localparam logic signed [SW-1:0] LIM_H  = SW'(SPR_H);
    localparam logic [31:0]          FRAME_SZ = 32'(SPR_W * SPR_H);

    typedef enum logic [1:0] {IDLE, WALK, JUMP} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_up_q, dir_up_d;
    logic          mirror_q, mirror_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            cnt_q    <= '0;
            dir_up_q <= 1'b1;
            mirror_q <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            mirror_q <= mirror_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        mirror_d = mirror_q;
        if (frame_tick) begin
            mirror_d = facing_left;
            if (jumping) begin
                state_d = JUMP;
                frame_d = FR_JUMP;
            end else begin
                unique case (state_q)
                    IDLE, JUMP: begin
                        if (walking) begin
                            state_d  = WALK;
                            frame_d  = FR_LO;
                            cnt_d    = '0;
                            dir_up_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            frame_d = FR_IDLE;
                        end
                    end
                    WALK: begin
                        if (!walking) begin
                            state_d = IDLE;
                            frame_d = FR_IDLE;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            cnt_d = '0;
                            // Ping-pong over the walk frames; a single walk frame never moves.
                            if (FR_LO != FR_HI) begin
                                if (dir_up_q) begin
                                    if (frame_q < FR_HI) frame_d = frame_q + FW'(1);
                                    else begin
                                        dir_up_d = 1'b0;
                                        frame_d  = frame_q - FW'(1);
                                    end
                                end else begin
                                    if (frame_q > FR_LO) frame_d = frame_q - FW'(1);
                                    else begin
                                        dir_up_d = 1'b1;
                                        frame_d  = frame_q + FW'(1);
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        frame_d = FR_IDLE;
                    end
                endcase
            end
        end
    end

    // Offsets are signed and two bits wider so sprites clipped at the screen edge cannot alias.
    logic signed [SW-1:0] dx, dy;
    logic                 in_box;
    logic [31:0]          col, addr_full;

    always_comb begin
        dx     = $signed({2'b00, drawxsig}) - ($signed({2'b00, spritexsig}) - HALF_W);
        dy     = $signed({2'b00, drawysig}) - ($signed({2'b00, spriteysig}) - HALF_H);
        in_box = !dx[SW-1] && (dx < LIM_W) && !dy[SW-1] && (dy < LIM_H);
        col    = mirror_q ? (32'(SPR_W - 1) - 32'($unsigned(dx))) : 32'($unsigned(dx));
        addr_full = 32'(BASE_ADDR) + 32'(frame_q) * FRAME_SZ
                  + 32'($unsigned(dy)) * 32'(SPR_W) + col;
        addr_d  = in_box ? addr_full[ADDR_W-1:0] : '0;
        valid_d = in_box;
    end

    assign read_address_mario = addr_q;
    assign pixel_valid        = valid_q;
    assign frame_number       = frame_q;

endmodule

// File: tb/tb_sprite_frame_animator.sv
// Directed plus randomized bench for sprite_frame_animator against an arithmetic reference model.
module tb_sprite_frame_animator;

    localparam int SPR_W = 20, SPR_H = 40, NF = 4, FT = 2, CW = 10, AW = 19, BASE = 0;
    localparam int FWB = $clog2(NF);

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic           frame_tick = 1'b0, walking = 1'b0, jumping = 1'b0, facing_left = 1'b0;
    logic [CW-1:0]  drawxsig = '0, drawysig = '0, spritexsig = '0, spriteysig = '0;
    logic [AW-1:0]  read_address_mario;
    logic           pixel_valid;
    logic [FWB-1:0] frame_number;

    int total = 0;
    int bad   = 0;

    sprite_frame_animator #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_TICKS(FT),
        .COORD_W(CW), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .walking(walking),
        .jumping(jumping), .facing_left(facing_left), .drawxsig(drawxsig), .drawysig(drawysig),
        .spritexsig(spritexsig), .spriteysig(spriteysig),
        .read_address_mario(read_address_mario), .pixel_valid(pixel_valid),
        .frame_number(frame_number)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Reference model: mode 0=idle 1=walk 2=jump; walk frame derived from ticks spent walking.
    int m_mode = 0, m_wk = 0, m_frame = 0;
    bit m_mir = 0;

    function automatic int pingpong(input int k);
        int l, p, m;
        l = NF - 2;
        if (l == 1) return 1;
        p = 2 * (l - 1);
        m = k % p;
        return (m < l) ? 1 + m : 1 + p - m;
    endfunction

    task automatic model_tick(input bit w, input bit j, input bit f);
        m_mir = f;
        if (j) begin
            m_mode = 2; m_frame = NF - 1;
        end else if (m_mode == 1) begin
            if (!w) begin
                m_mode = 0; m_frame = 0;
            end else begin
                m_wk++;
                m_frame = pingpong(m_wk / FT);
            end
        end else if (w) begin
            m_mode = 1; m_wk = 0; m_frame = pingpong(0);
        end else begin
            m_mode = 0; m_frame = 0;
        end
    endtask

    task automatic model_pixel(output int ea, output int ev);
        int dx, dy, col;
        dx = int'(drawxsig) - (int'(spritexsig) - SPR_W / 2);
        dy = int'(drawysig) - (int'(spriteysig) - SPR_H / 2);
        if (dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H) begin
            col = m_mir ? SPR_W - 1 - dx : dx;
            ea  = (BASE + m_frame * SPR_W * SPR_H + dy * SPR_W + col) & ((1 << AW) - 1);
            ev  = 1;
        end else begin
            ea = 0; ev = 0;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from pre-edge model state, then check after the edge.
    task automatic cyc(input bit tk, input bit w, input bit j, input bit f, input int x, input int y);
        int ea, ev;
        frame_tick = tk; walking = w; jumping = j; facing_left = f;
        drawxsig = CW'(x); drawysig = CW'(y);
        model_pixel(ea, ev);
        if (tk) model_tick(w, j, f);
        @(posedge Clk);
        #1;
        chk("addr",  int'(read_address_mario), ea);
        chk("valid", int'(pixel_valid), ev);
        chk("frame", int'(frame_number), m_frame);
    endtask

    int wseq [9] = '{1, 1, 2, 2, 1, 1, 2, 2, 1};

    initial begin
        // reset state
        #3;
        chk("rst_addr",  int'(read_address_mario), 0);
        chk("rst_valid", int'(pixel_valid), 0);
        chk("rst_frame", int'(frame_number), 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // idle addressing
        spritexsig = 10'd100; spriteysig = 10'd200;
        cyc(0, 0, 0, 0, 90, 180);
        chk("idle_org_addr", int'(read_address_mario), 0);
        chk("idle_org_valid", int'(pixel_valid), 1);
        cyc(0, 0, 0, 0, 109, 219);
        chk("idle_corner", int'(read_address_mario), 799);
        cyc(0, 0, 0, 0, 89, 180);
        chk("idle_left_out", int'(pixel_valid), 0);
        cyc(0, 0, 0, 0, 90, 220);
        chk("idle_below_out", int'(pixel_valid), 0);
        chk("idle_below_addr", int'(read_address_mario), 0);

        // walk cycle, each tick followed by a quiet cycle
        for (int k = 0; k < 9; k++) begin
            cyc(1, 1, 0, 0, 90, 180);
            chk("walk_seq", int'(frame_number), wseq[k]);
            cyc(0, 1, 0, 0, 90, 180);
            if (k == 2) chk("walk_f2_addr", int'(read_address_mario), 1600);
        end

        // mirror
        cyc(1, 1, 0, 1, 90, 180);
        cyc(0, 1, 0, 1, 90, 180);
        chk("mirror_left", int'(read_address_mario), 819);
        cyc(0, 1, 0, 1, 109, 180);
        chk("mirror_right", int'(read_address_mario), 800);
        cyc(0, 1, 0, 0, 90, 180);
        chk("mirror_hold", int'(read_address_mario), 819);

        // jump priority
        cyc(1, 1, 0, 0, 90, 180);
        chk("pre_jump_frame", int'(frame_number), 2);
        cyc(1, 1, 1, 0, 90, 180);
        chk("jump_frame", int'(frame_number), 3);
        cyc(0, 1, 1, 0, 90, 180);
        chk("jump_addr", int'(read_address_mario), 2400);
        cyc(1, 1, 0, 0, 90, 180);
        chk("land_walk", int'(frame_number), 1);
        cyc(1, 0, 0, 0, 90, 180);
        chk("land_idle", int'(frame_number), 0);

        // edge clip
        spritexsig = 10'd5; spriteysig = 10'd10;
        cyc(0, 0, 0, 0, 0, 0);
        chk("clip_addr", int'(read_address_mario), 205);
        chk("clip_valid", int'(pixel_valid), 1);
        cyc(0, 0, 0, 0, 1023, 0);
        chk("clip_nowrap", int'(pixel_valid), 0);

        // asynchronous reset mid-walk
        spritexsig = 10'd100; spriteysig = 10'd200;
        cyc(1, 1, 0, 0, 95, 190);
        cyc(0, 1, 0, 0, 95, 190);
        #3 Reset_n = 1'b0;
        #2;
        chk("arst_frame", int'(frame_number), 0);
        chk("arst_addr",  int'(read_address_mario), 0);
        chk("arst_valid", int'(pixel_valid), 0);
        m_mode = 0; m_wk = 0; m_frame = 0; m_mir = 0;
        #1 Reset_n = 1'b1;
        cyc(0, 1, 0, 0, 300, 300);
        cyc(0, 1, 0, 0, 95, 190);
        chk("post_rst_frame", int'(frame_number), 0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int x, y;
            if (n % 16 == 0) begin
                spritexsig = CW'($urandom_range(0, 1023));
                spriteysig = CW'($urandom_range(0, 1023));
            end
            x = (int'(spritexsig) - 14 + int'($urandom_range(0, 28))) & 1023;
            y = (int'(spriteysig) - 24 + int'($urandom_range(0, 48))) & 1023;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_frame_animator.md
Name: sprite_frame_animator

Overview:
- Registered, parametrised sprite-ROM address generator with an internal animation state machine.
- Chooses the sprite frame itself: idle, walk cycle or jump, advanced on vertical-blank ticks so frames never change mid-screen.
- Also provides horizontal mirroring and a bounding-box valid flag.
- Sits between the VGA controller (drawxsig/drawysig) and the sprite ROM; its output feeds the colour mapper.

Parameters:
- SPR_W, 20, sprite width in pixels.
- SPR_H, 40, sprite height in pixels.
- NUM_FRAMES, 4, frames stored back-to-back in ROM. Minimum 3. Frame 0 is idle, frames 1..NUM_FRAMES-2 are walk, frame NUM_FRAMES-1 is jump.
- FRAME_TICKS, 8, frame_tick pulses per walk-frame step (≥1).
- COORD_W, 10, screen coordinate width.
- ADDR_W, 19, ROM address width.
- BASE_ADDR, 0, ROM offset of frame 0.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per vertical blank
- walking  in  1  horizontal movement active
- jumping  in  1  airborne
- facing_left  in  1  mirror request
- drawxsig  in  COORD_W  current pixel x
- drawysig  in  COORD_W  current pixel y
- spritexsig  in  COORD_W  sprite centre x
- spriteysig  in  COORD_W  sprite centre y
- read_address_mario  out  ADDR_W  ROM address, registered
- pixel_valid  out  1  current pixel lies inside the sprite box, registered
- frame_number  out  clog2(NUM_FRAMES)  current frame index

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state=IDLE, frame_number=0, tick counter=0, ping-pong direction=up, mirror=0.
  - read_address_mario=0, pixel_valid=0.
- All state, counter and mirror updates happen only on cycles with frame_tick=1. Inputs are sampled on that same cycle. walking, jumping and facing_left are ignored on other cycles.
- FSM (evaluated on frame_tick):
  - IDLE: jumping → JUMP. Else walking → WALK with frame=1, counter=0, direction=up. Else stay, frame=0.
  - WALK: jumping → JUMP. Else !walking → IDLE, frame=0.
    - Otherwise counter++. When counter reaches FRAME_TICKS-1: counter=0, step frame.
    - Stepping ping-pongs between 1 and NUM_FRAMES-2, reversing at each end (NUM_FRAMES=4 gives 1,2,1,2…). If NUM_FRAMES=3, frame stays 1.
  - JUMP: frame=NUM_FRAMES-1. !jumping → WALK (frame=1, counter=0) if walking, else IDLE.
  - jumping has priority over walking in every state.
- mirror register ← facing_left on each frame_tick.
- Address path: 1-cycle latency from drawxsig/drawysig to outputs, using the state/frame/mirror values current at that edge.
  - dx = drawxsig − (spritexsig − SPR_W/2).
  - dy = drawysig − (spriteysig − SPR_H/2).
  - Both computed signed in COORD_W+2 bits; no wrap when the sprite is clipped at x or y = 0.
- In box (0 ≤ dx < SPR_W and 0 ≤ dy < SPR_H):
  - col = mirror ? SPR_W−1−dx : dx.
  - address = BASE_ADDR + frame·SPR_W·SPR_H + dy·SPR_W + col, truncated to ADDR_W.
  - pixel_valid=1.
- Out of box: address=0, pixel_valid=0.
- Simultaneous frame_tick and an in-box pixel: the registered address uses the old frame. The new frame applies from the following cycle.
- Reset mid-walk: outputs and FSM return to reset values immediately, with no waiting for Clk.

Test Plan:
- Reset: Reset_n=0 mid-stream with walking=1 → next sample shows frame_number=0, read_address_mario=0, pixel_valid=0. After release with no frame_tick, frame stays 0.
- Idle addressing: sprite (100,200), draw (90,180) → addr 0, valid 1 one cycle later. Draw (109,219) → 799. Draw (89,180) and (90,220) → valid 0, addr 0.
- Walk cycle: FRAME_TICKS=2, walking=1, 9 frame_ticks → frame sequence 1,1,2,2,1,1,2,2,1. Draw (90,180) in frame 2 → 1600. Frame changes only on the cycle after a tick.
- Mirror: frame 1, facing_left=1 sampled on a tick, draw (90,180) → 819. Draw (109,180) → 800. facing_left toggled between ticks → no change.
- Jump priority: in WALK frame 2, jumping=1 and walking=1 on one tick → frame 3, addr (90,180)=2400. Drop jumping with walking=1 → frame 1. Drop both → frame 0.
- Edge clip: sprite (5,10), draw (0,0) → dx=5, dy=10, addr 205 in frame 0, valid 1. Draw (1023,0) → valid 0, with no wrap-induced false hit.
